layer_blend_pipe: RTL and testbench
===================================

LAYER_BLEND_PIPE -- requirements
Module: layer_blend_pipe

Interface
REQ-001 SHALL provide parameter LAYERNUM, default 4, number of blended layers (1..16).
REQ-002 SHALL provide parameter CW, default 8, colour channel width in bits (4..12).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_frame_start  input  1  frame-boundary strobe; latches config.
REQ-006 SHALL have port i_valid  input  1  pixel on layer inputs is valid this cycle.
REQ-007 SHALL have ports i_LAYER_R, i_LAYER_G, i_LAYER_B  input  LAYERNUM x CW  per-layer pixel colour; index 0 is the bottom layer.
REQ-008 SHALL have port i_enableList  input  LAYERNUM  per-layer enable, raw (pre-shadow).
REQ-009 SHALL have port i_transList  input  LAYERNUM x 3  per-layer blend code, raw.
REQ-010 SHALL have port o_valid  output  1  blended pixel valid.
REQ-011 SHALL have ports o_VGA_R, o_VGA_G, o_VGA_B  output  CW each  blended colour, registered.
REQ-012 SHALL have port o_sat_count  output  16  saturated-pixel count for current frame.

Function
REQ-013 SHALL hold shadow copies of i_enableList/i_transList, loaded only in cycles where i_frame_start=1; raw changes at other times SHALL have no effect.
REQ-014 SHALL blend each pixel entirely with the shadow config in effect on its entry cycle, including new config loaded that same cycle; config SHALL travel down the pipeline with its pixel.
REQ-015 SHALL be fully pipelined: one input register stage plus one registered stage per layer; latency i_valid->o_valid exactly LAYERNUM+1 cycles; throughput one pixel per cycle; no stalls.
REQ-016 SHALL start each pixel with accumulator A=0 per channel, then apply layers 0..LAYERNUM-1 in order, layer k in stage k+1.
REQ-017 Disabled layer: A unchanged.
REQ-018 Codes 0,1,2,3: A = A - (A>>s) + (L>>s), s = 2,3,4,5 respectively.
REQ-019 Code 4: opaque, A = L.
REQ-020 Code 5: half, A = A - (A>>1) + (L>>1).
REQ-021 Code 6: additive, A = min(A+L, 2^CW-1); sum computed at CW+1 bits; overflow sets the pixel's sat flag (any channel, any layer).
REQ-022 Code 7: layer hidden, A unchanged.
REQ-023 Results of codes 0-5 never exceed 2^CW-1; no truncation beyond the stated shifts.
REQ-024 When o_valid=0, o_VGA_* SHALL hold their previous values.
REQ-025 Bubbles (i_valid=0) SHALL propagate as o_valid=0 with identical latency; stage data in bubbles is don't-care internally.

Reset
REQ-026 On i_rst=1: o_valid=0, o_VGA_*=0, o_sat_count=0, all pipeline valid bits 0, shadow enables 0, shadow codes 7.
REQ-027 Reset mid-stream SHALL discard all in-flight pixels; first o_valid after reset comes LAYERNUM+1 cycles after first accepted i_valid.
REQ-028 i_rst SHALL take priority over i_frame_start and i_valid in the same cycle.

Configuration
REQ-029 Macro LAYER_BLEND_SAT_STATS_EN SHALL compile in the saturation counter.
REQ-030 With macro: o_sat_count increments by 1 per output pixel with o_valid=1 and sat flag set, saturating at 0xFFFF; i_frame_start clears it to 0, and a pixel exiting in that cycle is not counted.
REQ-031 Without macro: o_sat_count tied to 0, no counter or sat-flag pipeline logic present.

Verification (LAYERNUM=4, CW=8)
REQ-032 Reset, frame_start with en=0001, code0=0, L0_R=200, one valid pixel -> o_valid 5 cycles later, o_VGA_R=50.
REQ-033 en=0011, code0=4 L0_R=100, code1=5 L1_R=200 -> o_VGA_R=150; code1=7 instead -> o_VGA_R=100.
REQ-034 code0=4 L0_G=200, code1=6 L1_G=100, macro on -> o_VGA_G=255, o_sat_count=1; next frame_start -> 0; macro off -> o_sat_count stays 0.
REQ-035 Change i_transList mid-frame without frame_start -> outputs unchanged; assert frame_start with a valid pixel -> that pixel and all later use new codes, pixels already in flight use old codes.
REQ-036 Stream 10 pixels with bubble pattern 1101..., assert i_rst mid-stream -> o_valid pattern matches input delayed 5 cycles until reset, then o_valid=0, o_VGA_*=0, no stale pixels emerge.

Source files
------------

// File: rtl/layer_blend_pipe.sv
// Multi-layer colour blend pipeline: one input register, then one registered blend stage per layer.
// Define LAYER_BLEND_SAT_STATS_EN to build the per-frame saturated-pixel counter (o_sat_count).
module layer_blend_pipe #(
  parameter int LAYERNUM = 4,
  parameter int CW       = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_start,
  input  logic                  i_valid,
  input  logic [LAYERNUM*CW-1:0] i_LAYER_R,
  input  logic [LAYERNUM*CW-1:0] i_LAYER_G,
  input  logic [LAYERNUM*CW-1:0] i_LAYER_B,
  input  logic [LAYERNUM-1:0]   i_enableList,
  input  logic [LAYERNUM*3-1:0] i_transList,
  output logic                  o_valid,
  output logic [CW-1:0]         o_VGA_R,
  output logic [CW-1:0]         o_VGA_G,
  output logic [CW-1:0]         o_VGA_B,
  output logic [15:0]           o_sat_count
);

  localparam logic [2:0] CODE_OPAQUE = 3'd4;
  localparam logic [2:0] CODE_HALF   = 3'd5;
  localparam logic [2:0] CODE_ADD    = 3'd6;
  localparam logic [2:0] CODE_HIDDEN = 3'd7;

  function automatic logic [CW-1:0] blend_ch(input logic [CW-1:0] a, input logic [CW-1:0] l,
                                             input logic [2:0] code);
    logic [CW:0] sum;
    logic [2:0]  sh;
    sum = {1'b0, a} + {1'b0, l};
    sh  = code + 3'd2;
    case (code)
      3'd0, 3'd1, 3'd2, 3'd3: blend_ch = a - (a >> sh) + (l >> sh);
      CODE_OPAQUE:            blend_ch = l;
      CODE_HALF:              blend_ch = a - (a >> 1) + (l >> 1);
      CODE_ADD:               blend_ch = sum[CW] ? {CW{1'b1}} : sum[CW-1:0];
      default:                blend_ch = a;
    endcase
  endfunction

  logic [LAYERNUM-1:0]   shadow_en_reg;
  logic [LAYERNUM*3-1:0] shadow_code_reg;
  logic [LAYERNUM-1:0]   cfg_en;
  logic [LAYERNUM*3-1:0] cfg_code;

  // A pixel entering on a frame_start cycle already uses the freshly loaded config.
  assign cfg_en   = i_frame_start ? i_enableList : shadow_en_reg;
  assign cfg_code = i_frame_start ? i_transList  : shadow_code_reg;

  // Stage 0 is the input register; stage k+1 holds the result after layer k.
  logic                  valid_reg [0:LAYERNUM];
  logic [CW-1:0]         acc_r_reg [0:LAYERNUM];
  logic [CW-1:0]         acc_g_reg [0:LAYERNUM];
  logic [CW-1:0]         acc_b_reg [0:LAYERNUM];
  logic [LAYERNUM-1:0]   en_reg    [0:LAYERNUM-1];
  logic [LAYERNUM*3-1:0] code_reg  [0:LAYERNUM-1];
  logic [LAYERNUM*CW-1:0] lr_reg   [0:LAYERNUM-1];
  logic [LAYERNUM*CW-1:0] lg_reg   [0:LAYERNUM-1];
  logic [LAYERNUM*CW-1:0] lb_reg   [0:LAYERNUM-1];

  logic [2:0]    op_code    [0:LAYERNUM-1];
  logic [CW-1:0] acc_r_next [0:LAYERNUM-1];
  logic [CW-1:0] acc_g_next [0:LAYERNUM-1];
  logic [CW-1:0] acc_b_next [0:LAYERNUM-1];

`ifdef LAYER_BLEND_SAT_STATS_EN
  function automatic logic add_ovf(input logic [CW-1:0] a, input logic [CW-1:0] l);
    logic [CW:0] sum;
    sum     = {1'b0, a} + {1'b0, l};
    add_ovf = sum[CW];
  endfunction

  logic        sat_reg  [0:LAYERNUM];
  logic        sat_next [0:LAYERNUM-1];
  logic [15:0] sat_count_reg;
`endif

  for (genvar gi = 0; gi < LAYERNUM; gi++) begin : g_layer
    // A disabled layer behaves exactly like a hidden one.
    assign op_code[gi]    = en_reg[gi][gi] ? code_reg[gi][gi*3 +: 3] : CODE_HIDDEN;
    assign acc_r_next[gi] = blend_ch(acc_r_reg[gi], lr_reg[gi][gi*CW +: CW], op_code[gi]);
    assign acc_g_next[gi] = blend_ch(acc_g_reg[gi], lg_reg[gi][gi*CW +: CW], op_code[gi]);
    assign acc_b_next[gi] = blend_ch(acc_b_reg[gi], lb_reg[gi][gi*CW +: CW], op_code[gi]);
`ifdef LAYER_BLEND_SAT_STATS_EN
    assign sat_next[gi] = sat_reg[gi] | ((op_code[gi] == CODE_ADD) &
                          (add_ovf(acc_r_reg[gi], lr_reg[gi][gi*CW +: CW]) |
                           add_ovf(acc_g_reg[gi], lg_reg[gi][gi*CW +: CW]) |
                           add_ovf(acc_b_reg[gi], lb_reg[gi][gi*CW +: CW])));
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_en_reg   <= '0;
      shadow_code_reg <= {LAYERNUM{CODE_HIDDEN}};
      for (int k = 0; k <= LAYERNUM; k++) begin
        valid_reg[k] <= 1'b0;
        acc_r_reg[k] <= '0;
        acc_g_reg[k] <= '0;
        acc_b_reg[k] <= '0;
      end
      for (int k = 0; k < LAYERNUM; k++) begin
        en_reg[k]   <= '0;
        code_reg[k] <= '0;
        lr_reg[k]   <= '0;
        lg_reg[k]   <= '0;
        lb_reg[k]   <= '0;
      end
    end else begin
      if (i_frame_start) begin
        shadow_en_reg   <= i_enableList;
        shadow_code_reg <= i_transList;
      end
      valid_reg[0] <= i_valid;
      if (i_valid) begin
        en_reg[0]    <= cfg_en;
        code_reg[0]  <= cfg_code;
        lr_reg[0]    <= i_LAYER_R;
        lg_reg[0]    <= i_LAYER_G;
        lb_reg[0]    <= i_LAYER_B;
        acc_r_reg[0] <= '0;
        acc_g_reg[0] <= '0;
        acc_b_reg[0] <= '0;
      end
      // Config and layer data travel with the pixel; bubbles leave stage data untouched.
      for (int k = 1; k < LAYERNUM; k++) begin
        if (valid_reg[k-1]) begin
          en_reg[k]   <= en_reg[k-1];
          code_reg[k] <= code_reg[k-1];
          lr_reg[k]   <= lr_reg[k-1];
          lg_reg[k]   <= lg_reg[k-1];
          lb_reg[k]   <= lb_reg[k-1];
        end
      end
      for (int k = 0; k < LAYERNUM; k++) begin
        valid_reg[k+1] <= valid_reg[k];
        if (valid_reg[k]) begin
          acc_r_reg[k+1] <= acc_r_next[k];
          acc_g_reg[k+1] <= acc_g_next[k];
          acc_b_reg[k+1] <= acc_b_next[k];
        end
      end
    end
  end

`ifdef LAYER_BLEND_SAT_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k <= LAYERNUM; k++) sat_reg[k] <= 1'b0;
      sat_count_reg <= '0;
    end else begin
      if (i_valid) sat_reg[0] <= 1'b0;
      for (int k = 0; k < LAYERNUM; k++) begin
        if (valid_reg[k]) sat_reg[k+1] <= sat_next[k];
      end
      // A saturated pixel sitting on the output during frame_start is dropped from the new count.
      if (i_frame_start)
        sat_count_reg <= '0;
      else if (valid_reg[LAYERNUM] && sat_reg[LAYERNUM] && sat_count_reg != 16'hFFFF)
        sat_count_reg <= sat_count_reg + 16'd1;
    end
  end

  assign o_sat_count = sat_count_reg;
`else
  assign o_sat_count = '0;
`endif

  assign o_valid = valid_reg[LAYERNUM];
  assign o_VGA_R = acc_r_reg[LAYERNUM];
  assign o_VGA_G = acc_g_reg[LAYERNUM];
  assign o_VGA_B = acc_b_reg[LAYERNUM];

endmodule

// File: tb/tb_layer_blend_pipe.sv
// Bench for layer_blend_pipe (LAYERNUM=4, CW=8): directed table, corner sequences, random stream vs model.
module tb_layer_blend_pipe;
  localparam int LN  = 4;
  localparam int CW  = 8;
  localparam int LAT = LN + 1;
`ifdef LAYER_BLEND_SAT_STATS_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, fs, v;
  logic [LN-1:0]  en;
  logic [LN*3-1:0] codes;
  logic [LN*CW-1:0] lr, lg, lb;
  logic           o_valid;
  logic [CW-1:0]  o_r, o_g, o_b;
  logic [15:0]    o_sat_count;

  always #5 clk = ~clk;

  layer_blend_pipe #(.LAYERNUM(LN), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(fs), .i_valid(v),
    .i_LAYER_R(lr), .i_LAYER_G(lg), .i_LAYER_B(lb),
    .i_enableList(en), .i_transList(codes),
    .o_valid(o_valid), .o_VGA_R(o_r), .o_VGA_G(o_g), .o_VGA_B(o_b),
    .o_sat_count(o_sat_count)
  );

  typedef struct { int due; int r; int g; int b; bit sat; } exp_t;
  typedef struct {
    logic [3:0] en; logic [11:0] codes; logic [31:0] r; logic [31:0] g; logic [31:0] b;
    logic [7:0] xr; logic [7:0] xg; logic [7:0] xb; logic xsat;
  } vec_t;

  exp_t q[$];
  int n_vec = 0, n_bad = 0, ncyc = 0;
  logic [LN-1:0]   sh_en;
  logic [LN*3-1:0] sh_code;
  int m_valid = 0, m_r = 0, m_g = 0, m_b = 0, m_cnt = 0;
  bit m_sat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Reference: walk the layers bottom to top with plain integer arithmetic.
  function automatic void ref_pixel(input logic [3:0] e, input logic [11:0] c_list,
                                    input logic [31:0] lay, output int acc, output bit sat);
    acc = 0; sat = 0;
    for (int k = 0; k < LN; k++) begin
      int l;
      int c;
      l = int'(lay[k*8 +: 8]);
      c = int'(c_list[k*3 +: 3]);
      if (!e[k] || c == 7) continue;
      if (c <= 3)      acc = acc - (acc >> (c + 2)) + (l >> (c + 2));
      else if (c == 4) acc = l;
      else if (c == 5) acc = acc - (acc >> 1) + (l >> 1);
      else begin
        acc = acc + l;
        if (acc > 255) begin acc = 255; sat = 1; end
      end
    end
  endfunction

  // Apply current inputs for one clock, advance the model, then check all outputs.
  task automatic tick();
    exp_t e;
    int ar, ag, ab;
    bit sr, sg, sb;
    if (rst || fs) m_cnt = 0;
    else if (SAT_EN && m_valid == 1 && m_sat && m_cnt < 65535) m_cnt++;
    if (rst) begin
      q.delete();
      sh_en = '0;
      sh_code = '1;
    end else begin
      if (fs) begin sh_en = en; sh_code = codes; end
      if (v) begin
        ref_pixel(sh_en, sh_code, lr, ar, sr);
        ref_pixel(sh_en, sh_code, lg, ag, sg);
        ref_pixel(sh_en, sh_code, lb, ab, sb);
        e.due = ncyc + LAT; e.r = ar; e.g = ag; e.b = ab; e.sat = sr | sg | sb;
        q.push_back(e);
      end
    end
    @(posedge clk);
    ncyc++;
    if (rst) begin
      m_valid = 0; m_r = 0; m_g = 0; m_b = 0; m_sat = 0;
    end else if (q.size() > 0 && q[0].due == ncyc) begin
      e = q.pop_front();
      m_valid = 1; m_r = e.r; m_g = e.g; m_b = e.b; m_sat = e.sat;
    end else begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("o_valid", {31'd0, o_valid}, m_valid);
    chk("o_vga_rgb", {8'd0, o_r, o_g, o_b}, {8'd0, m_r[7:0], m_g[7:0], m_b[7:0]});
    chk("o_sat_count", {16'd0, o_sat_count}, m_cnt);
  endtask

  vec_t tbl[7];

  initial begin
    rst = 1; fs = 0; v = 0; en = '0; codes = '0; lr = '0; lg = '0; lb = '0;
    sh_en = '0; sh_code = '1;
    tbl[0] = '{4'b0001, 12'hFF8, 32'd200, 32'd0, 32'd0, 8'd50, 8'd0, 8'd0, 1'b0};
    tbl[1] = '{4'b0011, 12'hFEC, 32'h0000C864, 32'd0, 32'd0, 8'd150, 8'd0, 8'd0, 1'b0};
    tbl[2] = '{4'b0011, 12'hFFC, 32'h0000C864, 32'd0, 32'd0, 8'd100, 8'd0, 8'd0, 1'b0};
    tbl[3] = '{4'b1111, 12'h68C, 32'hF028A050, 32'd0, 32'd0, 8'd92, 8'd0, 8'd0, 1'b0};
    tbl[4] = '{4'b1010, 12'h924, 32'h1E633C4D, 32'd0, 32'd0, 8'd30, 8'd0, 8'd0, 1'b0};
    tbl[5] = '{4'b0011, 12'hFF4, 32'd0, 32'd0, 32'h00009B64, 8'd0, 8'd0, 8'd255, 1'b0};
    tbl[6] = '{4'b0011, 12'hFF4, 32'd0, 32'h000064C8, 32'd0, 8'd0, 8'd255, 8'd0, 1'b1};

    tick(); tick();
    chk("reset_valid", {31'd0, o_valid}, 0);
    chk("reset_rgb", {8'd0, o_r, o_g, o_b}, 0);
    rst = 0;

    // Directed table: config latched with a single pixel, observed LAT cycles later.
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en; codes = tbl[i].codes; lr = tbl[i].r; lg = tbl[i].g; lb = tbl[i].b;
      fs = 1; v = 1; tick();
      fs = 0; v = 0;
      repeat (LAT - 1) tick();
      chk("tbl_valid", {31'd0, o_valid}, 1);
      chk("tbl_r", {24'd0, o_r}, {24'd0, tbl[i].xr});
      chk("tbl_g", {24'd0, o_g}, {24'd0, tbl[i].xg});
      chk("tbl_b", {24'd0, o_b}, {24'd0, tbl[i].xb});
      tick();
      chk("tbl_sat_count", {16'd0, o_sat_count}, SAT_EN ? {31'd0, tbl[i].xsat} : 0);
    end

    // Saturated pixel exiting on a frame_start cycle is not counted; count clears.
    v = 1; tick(); v = 0;
    repeat (LAT - 1) tick();
    chk("sat_exit_valid", {31'd0, o_valid}, 1);
    fs = 1; tick(); fs = 0;
    chk("sat_clear_fs", {16'd0, o_sat_count}, 0);
    tick();
    chk("sat_exit_uncounted", {16'd0, o_sat_count}, 0);

    // Raw config change without frame_start is ignored; in-flight pixels keep old codes.
    en = 4'b0001; codes = 12'hFFC; lr = 32'd100; lg = '0; lb = '0;
    fs = 1; v = 1; tick();
    fs = 0; codes = 12'hFF8; lr = 32'd200; tick();
    fs = 1; tick();
    fs = 0; v = 0; tick(); tick();
    chk("cfg_old_p1", {24'd0, o_r}, 100);
    tick();
    chk("cfg_old_p2", {24'd0, o_r}, 200);
    tick();
    chk("cfg_new_p3", {24'd0, o_r}, 50);
    tick();

    // Bubble pattern 1101 with a reset mid-stream.
    en = 4'hF; codes = 12'h924;
    for (int i = 0; i < 10; i++) begin
      rst = (i == 7);
      fs = (i == 0);
      v = (i < 7) && (i % 4 != 2);
      lr = $urandom; lg = $urandom; lb = $urandom;
      tick();
    end
    rst = 0; fs = 0; v = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      chk("post_rst_valid", {31'd0, o_valid}, 0);
      chk("post_rst_rgb", {8'd0, o_r, o_g, o_b}, 0);
    end

    // Random stream against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      fs = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      en = 4'($urandom); codes = 12'($urandom);
      lr = $urandom; lg = $urandom; lb = $urandom;
      tick();
    end
    rst = 0; fs = 0; v = 0;
    repeat (LAT + 2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
